sram_uart_host: RTL and testbench
=================================

Name: sram_uart_host

Overview:
Host-side initiator for the byte-serial SRAM/SoC command protocol spoken by the on-chip SRAM controller. Accepts word-level requests (SRAM write, SRAM read, SoC start, SoC stop) and serializes them into command and data bytes on a byte-stream TX interface. For reads, it collects the 4 returned bytes from a byte-stream RX interface and reassembles the 32-bit word. Sits between a test/boot sequencer (or bench) and the UART link feeding the SRAM controller.

Parameters:
ADDR_W, 5, SRAM word-address width; fixed to the command-byte address field bits [4:0].
TIMEOUT_W, 16, width of the read-response timeout counter.
RSP_TIMEOUT, 50000, idle cycles allowed between read-response bytes before an error response; 0 disables the timeout.

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  request present
req_ready  out  1  request accepted when req_valid && req_ready
req_op  in  2  00 write, 01 read, 10 SoC start, 11 SoC stop
req_addr  in  5  SRAM word address
req_wdata  in  32  write data
rsp_valid  out  1  one-cycle completion pulse; no backpressure
rsp_rdata  out  32  read data; 0 for non-read ops
rsp_err  out  1  read timed out; qualified by rsp_valid
tx_valid  out  1  byte to transmit
tx_ready  in  1  transmitter accepts byte when tx_valid && tx_ready
tx_data  out  8  byte to transmit
rx_valid  in  1  received byte present
rx_ready  out  1  byte consumed when rx_valid && rx_ready
rx_data  in  8  received byte
rx_stray  out  1  one-cycle pulse: byte consumed outside a read collection and discarded
busy  out  1  state != IDLE

Behaviour:
- Reset (async, rst_n low): state IDLE. tx_valid, tx_data, rsp_valid, rsp_rdata, rsp_err, rx_stray, byte counter, timeout counter and shift register all clear to 0. req_ready is 0 while rst_n is low and 1 in IDLE after release. Reset mid-transfer abandons it immediately; no rsp_valid is produced.
- Command byte encoding:
  - write = {3'b000, addr}
  - read = {3'b001, addr}
  - SoC start = 8'h40
  - SoC stop = 8'h80
- States: IDLE, CMD, WDATA, RCOLLECT, DONE.
- IDLE:
  - req_ready=1.
  - On accept, latch op, addr and wdata; go to CMD next cycle.
- CMD:
  - tx_valid=1 and tx_data=command byte, both held stable until tx_ready.
  - On accept: write goes to WDATA with byte counter=0; read goes to RCOLLECT with counter=0 and timeout counter=0; SoC start/stop go to DONE.
- WDATA:
  - tx_data = wdata[8*cnt+7 : 8*cnt], LSB byte first.
  - Counter advances on each accept.
  - Accepting byte 3 goes to DONE.
  - tx_valid is never deasserted between bytes unless a byte has been accepted; back-to-back accepts are allowed, 1 byte/cycle.
- RCOLLECT:
  - rx_ready=1.
  - On each consumed byte, shift = {rx_data, shift[31:8]}, counter++, timeout counter cleared.
  - The 4th byte goes to DONE with rsp_err=0.
  - Otherwise the timeout counter increments each cycle without a byte. If RSP_TIMEOUT != 0 and the counter reaches RSP_TIMEOUT, go to DONE with rsp_err=1 and rsp_rdata = partial shift value.
  - A byte arriving in the same cycle the timeout hits wins; the timeout is suppressed.
- DONE:
  - rsp_valid=1 for exactly one cycle, then return to IDLE.
  - rsp_rdata and rsp_err hold until the next rsp_valid.
- Outside RCOLLECT: rx_ready=1. Any consumed byte is discarded and pulses rx_stray; it never corrupts the shift register.
- Minimum latencies from request accept to rsp_valid, with tx_ready=1 and rx bytes available immediately:
  - SoC op: 3 cycles.
  - write: 7 cycles.
  - read: 7 cycles.
- req_addr bits are used as-is. The op field alone selects the upper command bits; the address does not affect them.
- Only one request is outstanding at a time; req_ready=0 in every non-IDLE state.

Test Plan:
- Write: op=00, addr=5'h07, wdata=32'hDEADBEEF, tx_ready=1 → tx bytes 07, EF, BE, AD, DE on consecutive cycles; rsp_valid 7 cycles after accept; rsp_err=0.
- Read: op=01, addr=5'h1F; rx returns 78, 56, 34, 12 → tx byte 3F; rsp_rdata=32'h12345678; rsp_err=0.
- Backpressure: write with tx_ready toggling 1 cycle on / 2 off → tx_data stable while tx_valid && !tx_ready; the byte sequence is identical to the write scenario.
- Timeout: RSP_TIMEOUT=20, read with only 2 response bytes (AA, BB) → rsp_valid 20 cycles after the last byte; rsp_err=1; rsp_rdata=32'hBBAA0000.
- SoC and stray bytes: op=10 then op=11 → tx 40 then 80; one rsp_valid per op. Inject rx byte 55 while in IDLE → rx_stray pulses; a following read still returns correct data.
- Async reset asserted during WDATA after 2 data bytes → all outputs 0 immediately; no rsp_valid; after release a new write completes normally.

Source files
------------

// File: rtl/sram_uart_host_if.sv
// Request/response, TX byte-stream and RX byte-stream signals of the SRAM UART host.
// The master side drives requests and the link; the slave side is the host engine.
interface sram_uart_host_if #(
  parameter int ADDR_W = 5
);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_op;
  logic [ADDR_W-1:0] req_addr;
  logic [31:0]       req_wdata;
  logic              rsp_valid;
  logic [31:0]       rsp_rdata;
  logic              rsp_err;
  logic              tx_valid;
  logic              tx_ready;
  logic [7:0]        tx_data;
  logic              rx_valid;
  logic              rx_ready;
  logic [7:0]        rx_data;
  logic              rx_stray;
  logic              busy;

  modport master (
    output req_valid, req_op, req_addr, req_wdata, tx_ready, rx_valid, rx_data,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, tx_valid, tx_data, rx_ready,
           rx_stray, busy
  );

  modport slave (
    input  req_valid, req_op, req_addr, req_wdata, tx_ready, rx_valid, rx_data,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, tx_valid, tx_data, rx_ready,
           rx_stray, busy
  );
endinterface

// File: rtl/sram_uart_host.sv
// Serializes word-level SRAM/SoC requests into command and data bytes and
// reassembles 4-byte read responses, with a per-byte response timeout.
module sram_uart_host #(
  parameter int ADDR_W      = 5,
  parameter int TIMEOUT_W   = 16,
  parameter int RSP_TIMEOUT = 50000
) (
  input logic              clk,
  input logic              rst_n,
  sram_uart_host_if.slave  bus
);
  localparam logic [2:0] IDLE     = 3'd0;
  localparam logic [2:0] CMD      = 3'd1;
  localparam logic [2:0] WDATA    = 3'd2;
  localparam logic [2:0] RCOLLECT = 3'd3;
  localparam logic [2:0] DONE     = 3'd4;

  localparam logic [1:0] OP_WR = 2'b00;
  localparam logic [1:0] OP_RD = 2'b01;

  localparam bit                   TMO_EN   = (RSP_TIMEOUT != 0);
  localparam logic [TIMEOUT_W-1:0] TMO_LAST = TIMEOUT_W'(RSP_TIMEOUT - 1);

  logic [2:0]           state_q, state_d;
  logic [1:0]           op_q, op_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [1:0]           cnt_q, cnt_d;
  logic [TIMEOUT_W-1:0] tmo_q, tmo_d;
  logic [31:0]          shift_q, shift_d;
  logic                 err_q, err_d;
  logic                 tx_valid_q, tx_valid_d;
  logic [7:0]           tx_data_q, tx_data_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [31:0]          rsp_rdata_q, rsp_rdata_d;
  logic                 rsp_err_q, rsp_err_d;
  logic                 rx_stray_q, rx_stray_d;

  logic req_ready, req_fire, tx_fire, rx_fire;

  // The op field alone picks the upper command bits; SoC commands carry no address.
  function automatic logic [7:0] cmd_byte(input logic [1:0] op, input logic [ADDR_W-1:0] addr);
    case (op)
      2'b00:   cmd_byte = {3'b000, addr};
      2'b01:   cmd_byte = {3'b001, addr};
      2'b10:   cmd_byte = 8'h40;
      default: cmd_byte = 8'h80;
    endcase
  endfunction

  assign req_ready = rst_n && (state_q == IDLE);
  assign req_fire  = bus.req_valid && req_ready;
  assign tx_fire   = tx_valid_q && bus.tx_ready;
  assign rx_fire   = bus.rx_valid;

  always_comb begin
    // NOTE: every *_d starts from its held value so no path leaves a signal unassigned (no latches).
    state_d     = state_q;
    op_d        = op_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    tmo_d       = tmo_q;
    shift_d     = shift_q;
    err_d       = err_q;
    tx_valid_d  = tx_valid_q;
    tx_data_d   = tx_data_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    rx_stray_d  = rx_fire && (state_q != RCOLLECT);

    case (state_q)
      IDLE: if (req_fire) begin
        op_d       = bus.req_op;
        addr_d     = bus.req_addr;
        wdata_d    = bus.req_wdata;
        tx_valid_d = 1'b1;
        tx_data_d  = cmd_byte(bus.req_op, bus.req_addr);
        state_d    = CMD;
      end
      CMD: if (tx_fire) begin
        cnt_d = 2'd0;
        if (op_q == OP_WR) begin
          tx_data_d = wdata_q[7:0];
          state_d   = WDATA;
        end else if (op_q == OP_RD) begin
          tx_valid_d = 1'b0;
          tmo_d      = '0;
          shift_d    = '0;
          err_d      = 1'b0;
          state_d    = RCOLLECT;
        end else begin
          tx_valid_d = 1'b0;
          state_d    = DONE;
        end
      end
      WDATA: if (tx_fire) begin
        if (cnt_q == 2'd3) begin
          tx_valid_d = 1'b0;
          state_d    = DONE;
        end else begin
          cnt_d     = cnt_q + 2'd1;
          tx_data_d = wdata_q[{cnt_q + 2'd1, 3'b000} +: 8];
        end
      end
      RCOLLECT: begin
        // A byte landing on the timeout cycle takes priority over the timeout.
        if (rx_fire) begin
          shift_d = {bus.rx_data, shift_q[31:8]};
          cnt_d   = cnt_q + 2'd1;
          tmo_d   = '0;
          if (cnt_q == 2'd3) state_d = DONE;
        end else if (TMO_EN && (tmo_q == TMO_LAST)) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          tmo_d = tmo_q + 1'b1;
        end
      end
      DONE: begin
        rsp_valid_d = 1'b1;
        rsp_rdata_d = (op_q == OP_RD) ? shift_q : 32'h0;
        rsp_err_d   = (op_q == OP_RD) && err_q;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      op_q        <= 2'b00;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      tmo_q       <= '0;
      shift_q     <= '0;
      err_q       <= 1'b0;
      tx_valid_q  <= 1'b0;
      tx_data_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
      rx_stray_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking updates so every flop samples pre-edge values.
      state_q     <= state_d;
      op_q        <= op_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      tmo_q       <= tmo_d;
      shift_q     <= shift_d;
      err_q       <= err_d;
      tx_valid_q  <= tx_valid_d;
      tx_data_q   <= tx_data_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
      rx_stray_q  <= rx_stray_d;
    end
  end

  assign bus.req_ready = req_ready;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
  assign bus.tx_valid  = tx_valid_q;
  assign bus.tx_data   = tx_data_q;
  assign bus.rx_ready  = 1'b1;
  assign bus.rx_stray  = rx_stray_q;
  assign bus.busy      = (state_q != IDLE);
endmodule

// File: tb/tb_sram_uart_host.sv
// Bench for sram_uart_host: table of requests with TX/response scoreboards,
// plus hand sequences for stray RX bytes and mid-transfer reset.
module tb_sram_uart_host;
  localparam int TMO = 20;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sram_uart_host_if bus ();
  sram_uart_host #(.ADDR_W(5), .TIMEOUT_W(16), .RSP_TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  addr;
    logic [31:0] wdata;
    logic [31:0] rxw;       // response bytes, LSB first
    int          nrx;
    int          gap;       // idle cycles before the last response byte
    bit          bp;        // tx_ready 1 on / 2 off
    logic [7:0]  exp_cmd;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;   // accept cycle to rsp_valid cycle; 0 = not checked
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
  } rsp_t;

  int total = 0;
  int bad = 0;
  int tx_count = 0;
  int cyc = 0;
  bit bp_mode = 1'b0;
  logic [7:0] exp_tx[$];
  rsp_t exp_rsp[$];
  bit stall_prev = 1'b0;
  logic [7:0] prev_data = 8'h00;
  vec_t tbl[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic flag(input string name);
    total++;
    bad++;
    $display("FAIL %s: got event want none", name);
  endtask

  always @(posedge clk) begin
    #1;
    cyc++;
    bus.tx_ready = !bp_mode || (cyc % 3 == 0);
  end

  // Monitor: TX bytes and responses are popped from the scoreboards as they appear.
  always @(negedge clk) begin
    rsp_t er;
    logic [7:0] eb;
    if (stall_prev) begin
      check("tx_hold_valid", {31'b0, bus.tx_valid}, 32'd1);
      check("tx_hold_data", {24'b0, bus.tx_data}, {24'b0, prev_data});
    end
    stall_prev = bus.tx_valid && !bus.tx_ready;
    prev_data  = bus.tx_data;
    if (bus.tx_valid && bus.tx_ready) begin
      tx_count++;
      if (exp_tx.size() == 0) flag("tx_unexpected");
      else begin
        eb = exp_tx.pop_front();
        check("tx_byte", {24'b0, bus.tx_data}, {24'b0, eb});
      end
    end
    if (bus.rsp_valid) begin
      if (exp_rsp.size() == 0) flag("rsp_unexpected");
      else begin
        er = exp_rsp.pop_front();
        check("rsp_rdata", bus.rsp_rdata, er.rdata);
        check("rsp_err", {31'b0, bus.rsp_err}, {31'b0, er.err});
      end
    end
  end

  task automatic drive_req(input vec_t v, output int lat);
    int n;
    lat = 0;
    @(posedge clk); #1;
    bus.req_valid = 1'b1;
    bus.req_op    = v.op;
    bus.req_addr  = v.addr;
    bus.req_wdata = v.wdata;
    n = 0;
    do begin @(negedge clk); n++; end while (!bus.req_ready && n < 50);
    if (!bus.req_ready) flag("req_accept_timeout");
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    n = 0;
    do begin @(negedge clk); lat++; end while (!bus.rsp_valid && lat < 300);
    if (!bus.rsp_valid) flag("rsp_wait_timeout");
    @(negedge clk);
    check("rsp_one_cycle", {31'b0, bus.rsp_valid}, 32'd0);
  endtask

  task automatic feed_rx(input vec_t v);
    int n = 0;
    do begin @(negedge clk); #1; n++; end
      while (!(bus.tx_valid && bus.tx_ready && bus.tx_data == v.exp_cmd) && n < 100);
    if (n >= 100) flag("read_cmd_timeout");
    @(posedge clk); #1;
    for (int i = 0; i < v.nrx; i++) begin
      if (i == v.nrx - 1 && v.gap > 0) begin
        bus.rx_valid = 1'b0;
        repeat (v.gap) begin @(posedge clk); #1; end
      end
      bus.rx_valid = 1'b1;
      bus.rx_data  = v.rxw[8*i +: 8];
      @(posedge clk); #1;
    end
    bus.rx_valid = 1'b0;
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    rsp_t r;
    bp_mode = v.bp;
    exp_tx.push_back(v.exp_cmd);
    if (v.op == 2'b00)
      for (int i = 0; i < 4; i++) exp_tx.push_back(v.wdata[8*i +: 8]);
    r.rdata = v.exp_rdata;
    r.err   = v.exp_err;
    exp_rsp.push_back(r);
    fork
      drive_req(v, lat);
      begin if (v.op == 2'b01) feed_rx(v); end
    join
    if (v.exp_lat != 0) check("latency", lat, v.exp_lat);
    bp_mode = 1'b0;
  endtask

  initial begin
    int n;
    // op addr wdata rxw nrx gap bp | cmd rdata err lat
    tbl[0] = '{2'b00, 5'h07, 32'hDEADBEEF, 32'h0,        0, 0,  1'b0, 8'h07, 32'h0,        1'b0, 7};
    tbl[1] = '{2'b01, 5'h1F, 32'h0,        32'h12345678, 4, 0,  1'b0, 8'h3F, 32'h12345678, 1'b0, 7};
    tbl[2] = '{2'b00, 5'h07, 32'hDEADBEEF, 32'h0,        0, 0,  1'b1, 8'h07, 32'h0,        1'b0, 0};
    tbl[3] = '{2'b10, 5'h1F, 32'hFFFFFFFF, 32'h0,        0, 0,  1'b0, 8'h40, 32'h0,        1'b0, 3};
    tbl[4] = '{2'b11, 5'h0A, 32'h0,        32'h0,        0, 0,  1'b0, 8'h80, 32'h0,        1'b0, 3};
    tbl[5] = '{2'b00, 5'h1F, 32'h00000000, 32'h0,        0, 0,  1'b0, 8'h1F, 32'h0,        1'b0, 7};
    tbl[6] = '{2'b01, 5'h00, 32'h0,        32'hA5C30F01, 4, 0,  1'b0, 8'h20, 32'hA5C30F01, 1'b0, 7};
    // Two bytes then silence: TMO idle cycles, then DONE and the response cycle.
    tbl[7] = '{2'b01, 5'h03, 32'h0,        32'h0000BBAA, 2, 0,  1'b0, 8'h23, 32'hBBAA0000, 1'b1, 5 + TMO};
    // Last byte arrives on exactly the cycle the timeout would fire.
    tbl[8] = '{2'b01, 5'h04, 32'h0,        32'h44332211, 4, 19, 1'b0, 8'h24, 32'h44332211, 1'b0, 26};

    bus.req_valid = 1'b0; bus.req_op = 2'b00; bus.req_addr = '0; bus.req_wdata = '0;
    bus.rx_valid = 1'b0; bus.rx_data = '0; bus.tx_ready = 1'b1;

    #3;
    check("rst_req_ready", {31'b0, bus.req_ready}, 32'd0);
    check("rst_tx_valid",  {31'b0, bus.tx_valid}, 32'd0);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 32'd0);
    check("rst_rsp_rdata", bus.rsp_rdata, 32'd0);
    check("rst_busy",      {31'b0, bus.busy}, 32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check("idle_req_ready", {31'b0, bus.req_ready}, 32'd1);

    // Stray RX byte while idle.
    @(posedge clk); #1;
    bus.rx_valid = 1'b1; bus.rx_data = 8'h55;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
    @(negedge clk);
    check("rx_stray_pulse", {31'b0, bus.rx_stray}, 32'd1);
    @(negedge clk);
    check("rx_stray_clear", {31'b0, bus.rx_stray}, 32'd0);

    for (int i = 0; i < 9; i++) run_vec(tbl[i]);

    // Reset after two write data bytes.
    n = tx_count;
    exp_tx.push_back(8'h0C); exp_tx.push_back(8'h44); exp_tx.push_back(8'h33);
    exp_tx.push_back(8'h22); exp_tx.push_back(8'h11);
    @(posedge clk); #1;
    bus.req_valid = 1'b1; bus.req_op = 2'b00; bus.req_addr = 5'h0C; bus.req_wdata = 32'h11223344;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    for (int k = 0; k < 50 && tx_count < n + 3; k++) begin @(negedge clk); #1; end
    check("reset_pre_bytes", tx_count, n + 3);
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    exp_tx.delete();
    check("mid_rst_tx_valid", {31'b0, bus.tx_valid}, 32'd0);
    check("mid_rst_tx_data",  {24'b0, bus.tx_data}, 32'd0);
    check("mid_rst_busy",     {31'b0, bus.busy}, 32'd0);
    check("mid_rst_req_ready",{31'b0, bus.req_ready}, 32'd0);
    check("mid_rst_rsp",      {bus.rsp_rdata[30:0], bus.rsp_valid | bus.rsp_err | bus.rx_stray}, 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("post_rst_no_rsp", {31'b0, bus.rsp_valid}, 32'd0);
    end
    run_vec(tbl[0]);

    repeat (3) @(negedge clk);
    check("tx_queue_empty", exp_tx.size(), 32'd0);
    check("rsp_queue_empty", exp_rsp.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
